red_pitaya_fads_mc: RTL and testbench
=====================================

# red_pitaya_fads_mc

Multi-channel, parametrised fluorescence-activated droplet sorter for the ADC clock domain. It detects droplets on a selectable gate channel, tracks the per-channel peak intensity and the droplet width, and classifies each droplet against per-channel intensity windows and a width window. Positive droplets fire a sort pulse after a programmable delay. Thresholds and statistics are exposed on the system bus.

## Interface
Parameters:
- NCH, 2, number of ADC channels (1..4).
- DWT, 14, signed sample width.
- CW, 32, width of the counter, width and timer registers.

Ports:
- adc_clk_i  in  1  ADC clock, single clock domain. One clock; reset is asynchronous and active-high.
- adc_rst_i  in  1  asynchronous active-high reset.
- adc_i  in  NCH*DWT  signed samples; channel k is in bits [k*DWT +: DWT].
- sort_trig  out  1  sort pulse to the ASG trigger.
- busy  out  1  high in states DELAY and SORT.
- debug  out  4  current state code.
- sys_addr  in  32  bus address.
- sys_wdata  in  32  bus write data.
- sys_sel  in  4  byte select (ignored; full-word writes).
- sys_wen  in  1  write strobe.
- sys_ren  in  1  read strobe.
- sys_rdata  out  32  read data.
- sys_err  out  1  error (always 0).
- sys_ack  out  1  acknowledge.

## Operation
- States: IDLE=0, WAIT=1, ACQ=2, EVAL=3, DELAY=4, SORT=5.
- IDLE: go to WAIT when ctrl.enable=1.
- WAIT: when gate sample ≥ min_thr, set width=1 and capture peak[k]=adc_i[k] for all k, then go to ACQ.
- ACQ:
  - width increments and saturates at all-ones.
  - peak[k] updates when a sample is strictly greater than peak[k].
  - Go to EVAL when the gate sample < end threshold.
- EVAL (one cycle):
  - Positive = width in [wlow, whigh) and, for every channel with chmask[k]=1, peak[k] in [low_thr[k], high_thr[k]).
  - Counters: detected+1 always; positive+1 if positive; short+1 if width<wlow; long+1 if width≥whigh.
  - If positive and ctrl.sort_en=1, go to DELAY and load the timer; otherwise go to WAIT.
- DELAY: wait sort_delay cycles, then go to SORT. sort_delay=0 goes to SORT on the next cycle.
- SORT: sort_trig=1 for exactly sort_dur cycles, then go to WAIT and increment sorted. sort_dur=0 produces no pulse but still increments sorted.
- Droplets arriving during DELAY or SORT are not acquired. Each gate rising crossing of min_thr seen in these states increments missed.
- All counters saturate at all-ones.
- ctrl.soft_rst=1: the next state is IDLE from any state and sort_trig drops on the next edge. Registers keep their values.
- ctrl.clr: writing 1 zeroes all statistics counters in the same cycle. This bit self-clears and reads as 0.
- Signed comparisons apply to all intensity thresholds and peaks. Unsigned comparisons apply to widths and timers.
- Register map (offset, bits):
  - 0x00 ctrl: [0] enable, [1] sort_en, [2] soft_rst, [3] clr, [5:4] gate channel.
  - 0x04 min_thr.
  - 0x08 hyst.
  - 0x10 wlow; 0x14 whigh.
  - 0x18 sort_delay; 0x1C sort_dur.
  - 0x20 chmask.
  - 0x40+8k low_thr[k]; 0x44+8k high_thr[k].
  - Counters, read-only: 0x100 detected, 0x104 positive, 0x108 short, 0x10C long, 0x110 sorted, 0x114 missed.
  - 0x120 last width, read-only.
  - 0x140+4k last peak[k], read-only and sign-extended.
- Unmapped addresses read 0. Writes to read-only addresses are ignored.

## Timing
- Reset values:
  - sort_trig=0, busy=0, debug=0, sys_ack=0, sys_err=0, sys_rdata=0.
  - State IDLE; counters 0.
  - ctrl=0x3 (enable and sort_en set).
  - min_thr=15, hyst=0, wlow=1, whigh=all-ones, sort_delay=0, sort_dur=125000, chmask=1.
  - low_thr[k]=16, high_thr[k]=255.
- sys_ack is asserted one cycle after sys_wen or sys_ren, for one cycle. sys_rdata is valid in the same cycle as sys_ack.
- Latency: gate crossing at edge n gives ACQ at n+1. The sample that falls below the end threshold at edge m gives EVAL at m+1. sort_trig rises at EVAL+1+sort_delay.
- A register write lands on the edge where sys_wen is sampled. A threshold write during ACQ takes effect on the next comparison.
- A bus clear in the same cycle as a counter increment: the clear wins.

## Configuration
- FADS_HYST_EN defined: end threshold = min_thr − hyst. The subtraction saturates at the most negative DWT value, and hyst is writable.
- Undefined: end threshold = min_thr. hyst reads 0 and writes to it are ignored.

## Test plan
- Gate pulse of 100 at ch0 lasting 20 cycles, with thresholds 15/16/255, wlow=5, whigh=50, delay=10, dur=8:
  - detected=1, positive=1, sorted=1.
  - sort_trig high for exactly 8 cycles, starting 11 cycles after EVAL.
- Ch1 peak 300 with chmask=0b11 and ch1 window [16,255): positive=0, sorted=0, and sort_trig stays low.
- Second droplet arriving during SORT: missed=1, detected unchanged, and that droplet is not acquired.
- soft_rst written mid-SORT: sort_trig low on the next edge, debug=0, counters retained.
- With FADS_HYST_EN and hyst=5, a gate signal dwelling at 12: the droplet stays in ACQ. The same signal ends the droplet without the macro.
- Width counter pinned at all-ones with whigh=all-ones: long=1 and no wrap to 0.

Source files
------------

// File: rtl/red_pitaya_fads_mc_if.sv
// red_pitaya_fads_mc_if: system bus between the register master and the FADS core
interface red_pitaya_fads_mc_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        wen;
    logic        ren;
    logic        err;
    logic        ack;
    modport master (output addr, wdata, sel, wen, ren, input rdata, err, ack);
    modport slave (input addr, wdata, sel, wen, ren, output rdata, err, ack);
endinterface

// File: rtl/red_pitaya_fads_mc.sv
// red_pitaya_fads_mc: multi-channel droplet detector/sorter; define FADS_HYST_EN to end droplets at min_thr - hyst
module red_pitaya_fads_mc #(
    parameter int NCH = 2,
    parameter int DWT = 14,
    parameter int CW  = 32
) (
    input  logic               adc_clk_i,
    input  logic               adc_rst_i,
    input  logic [NCH*DWT-1:0] adc_i,
    output logic               sort_trig,
    output logic               busy,
    output logic [3:0]         debug,
    red_pitaya_fads_mc_if.slave sys
);
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        WAIT  = 4'd1,
        ACQ   = 4'd2,
        EVAL  = 4'd3,
        DELAY = 4'd4,
        SORT  = 4'd5
    } state_t;

    localparam logic signed [DWT-1:0] SMIN = {1'b1, {(DWT-1){1'b0}}};
    localparam logic signed [DWT-1:0] SMAX = {1'b0, {(DWT-1){1'b1}}};

    state_t state, state_n;
    logic enable, sort_en, soft_rst;
    logic [1:0] gate_ch;
    logic signed [DWT-1:0] min_thr, hyst, gate, end_thr;
    logic [CW-1:0] wlow, whigh, sort_delay, sort_dur;
    logic [NCH-1:0] chmask;
    logic signed [DWT-1:0] low_thr [NCH];
    logic signed [DWT-1:0] high_thr [NCH];
    logic signed [DWT-1:0] peak [NCH];
    logic signed [DWT-1:0] samp [4];
    logic [CW-1:0] width, timer, timer_n;
    logic [CW-1:0] cnt_det, cnt_pos, cnt_short, cnt_long, cnt_sorted, cnt_missed;
    logic above, above_q, ending, positive, clr, sorted_inc, missed_inc;
    logic [31:0] rd;
    logic unused_sel;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
        return &x ? x : x + 1'b1;
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_samp
        if (k < NCH) begin : g_on
            assign samp[k] = adc_i[k*DWT +: DWT];
        end else begin : g_off
            assign samp[k] = '0;
        end
    end

`ifdef FADS_HYST_EN
    logic signed [DWT+1:0] diff;
    assign diff    = (DWT+2)'(min_thr) - (DWT+2)'(hyst);
    assign end_thr = diff < (DWT+2)'(SMIN) ? SMIN : diff > (DWT+2)'(SMAX) ? SMAX : diff[DWT-1:0];
`else
    assign end_thr = min_thr;
`endif

    assign gate       = samp[gate_ch];
    assign above      = gate >= min_thr;
    assign ending     = gate < end_thr;
    assign clr        = sys.wen && sys.addr == 32'h0 && sys.wdata[3];
    assign sorted_inc = state == SORT && timer <= CW'(1) && !soft_rst;
    assign missed_inc = (state == DELAY || state == SORT) && above && !above_q;
    assign busy       = state == DELAY || state == SORT;
    assign debug      = state;
    assign sys.err    = 1'b0;
    assign unused_sel = ^sys.sel;

    // droplet is positive when its width and every enabled channel peak fall in their windows
    always_comb begin
        positive = width >= wlow && width < whigh;
        for (int k = 0; k < NCH; k++)
            if (chmask[k] && (peak[k] < low_thr[k] || peak[k] >= high_thr[k])) positive = 1'b0;
    end

    // next-state and timer logic; soft reset overrides everything
    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            IDLE:  if (enable) state_n = WAIT;
            WAIT:  state_n = !enable ? IDLE : above ? ACQ : WAIT;
            ACQ:   if (ending) state_n = EVAL;
            EVAL: begin
                state_n = positive && sort_en ? DELAY : WAIT;
                timer_n = sort_delay;
            end
            DELAY: begin
                state_n = timer <= CW'(1) ? SORT : DELAY;
                timer_n = timer <= CW'(1) ? sort_dur : timer - 1'b1;
            end
            SORT: begin
                state_n = timer <= CW'(1) ? WAIT : SORT;
                timer_n = timer <= CW'(1) ? timer : timer - 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (soft_rst) state_n = IDLE;
    end

    // state register; sort_trig is registered from the next state so it is glitch-free
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            state     <= IDLE;
            timer     <= '0;
            sort_trig <= 1'b0;
            above_q   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            sort_trig <= state_n == SORT && timer_n != '0;
            above_q   <= above;
        end
    end

    // width and peak tracking: captured on the opening sample, extended while the gate stays up
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            width <= '0;
            for (int k = 0; k < NCH; k++) peak[k] <= '0;
        end else if (state == WAIT && state_n == ACQ) begin
            width <= CW'(1);
            for (int k = 0; k < NCH; k++) peak[k] <= samp[k];
        end else if (state == ACQ && !ending) begin
            width <= sat(width);
            for (int k = 0; k < NCH; k++) if (samp[k] > peak[k]) peak[k] <= samp[k];
        end
    end

    // saturating statistics counters; a bus clear beats any simultaneous increment
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i || clr) begin
            cnt_det    <= '0;
            cnt_pos    <= '0;
            cnt_short  <= '0;
            cnt_long   <= '0;
            cnt_sorted <= '0;
            cnt_missed <= '0;
        end else begin
            if (state == EVAL) begin
                cnt_det <= sat(cnt_det);
                if (positive) cnt_pos <= sat(cnt_pos);
                if (width < wlow) cnt_short <= sat(cnt_short);
                if (width >= whigh) cnt_long <= sat(cnt_long);
            end
            if (sorted_inc) cnt_sorted <= sat(cnt_sorted);
            if (missed_inc) cnt_missed <= sat(cnt_missed);
        end
    end

    // configuration registers written from the bus
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            enable     <= 1'b1;
            sort_en    <= 1'b1;
            soft_rst   <= 1'b0;
            gate_ch    <= '0;
            min_thr    <= DWT'(15);
            hyst       <= '0;
            wlow       <= CW'(1);
            whigh      <= '1;
            sort_delay <= '0;
            sort_dur   <= CW'(125000);
            chmask     <= NCH'(1);
            for (int k = 0; k < NCH; k++) begin
                low_thr[k]  <= DWT'(16);
                high_thr[k] <= DWT'(255);
            end
        end else if (sys.wen) begin
            case (sys.addr)
                32'h00: begin
                    enable   <= sys.wdata[0];
                    sort_en  <= sys.wdata[1];
                    soft_rst <= sys.wdata[2];
                    gate_ch  <= sys.wdata[5:4];
                end
                32'h04: min_thr <= sys.wdata[DWT-1:0];
`ifdef FADS_HYST_EN
                32'h08: hyst <= sys.wdata[DWT-1:0];
`endif
                32'h10: wlow <= sys.wdata[CW-1:0];
                32'h14: whigh <= sys.wdata[CW-1:0];
                32'h18: sort_delay <= sys.wdata[CW-1:0];
                32'h1C: sort_dur <= sys.wdata[CW-1:0];
                32'h20: chmask <= sys.wdata[NCH-1:0];
                default: ;
            endcase
            for (int k = 0; k < NCH; k++) begin
                if (sys.addr == 32'h40 + 32'(8*k)) low_thr[k] <= sys.wdata[DWT-1:0];
                if (sys.addr == 32'h44 + 32'(8*k)) high_thr[k] <= sys.wdata[DWT-1:0];
            end
        end
    end

    // read decode; signed values are sign-extended, unmapped addresses read zero
    always_comb begin
        rd = '0;
        case (sys.addr)
            32'h000: rd = {26'd0, gate_ch, 1'b0, soft_rst, sort_en, enable};
            32'h004: rd = 32'(min_thr);
            32'h008: rd = 32'(hyst);
            32'h010: rd = 32'(wlow);
            32'h014: rd = 32'(whigh);
            32'h018: rd = 32'(sort_delay);
            32'h01C: rd = 32'(sort_dur);
            32'h020: rd = 32'(chmask);
            32'h100: rd = 32'(cnt_det);
            32'h104: rd = 32'(cnt_pos);
            32'h108: rd = 32'(cnt_short);
            32'h10C: rd = 32'(cnt_long);
            32'h110: rd = 32'(cnt_sorted);
            32'h114: rd = 32'(cnt_missed);
            32'h120: rd = 32'(width);
            default: ;
        endcase
        for (int k = 0; k < NCH; k++) begin
            if (sys.addr == 32'h40 + 32'(8*k)) rd = 32'(low_thr[k]);
            if (sys.addr == 32'h44 + 32'(8*k)) rd = 32'(high_thr[k]);
            if (sys.addr == 32'h140 + 32'(4*k)) rd = 32'(peak[k]);
        end
    end

    // one-cycle acknowledge with read data presented alongside it
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            sys.ack   <= 1'b0;
            sys.rdata <= '0;
        end else begin
            sys.ack   <= sys.wen || sys.ren;
            sys.rdata <= sys.ren ? rd : '0;
        end
    end
endmodule

// File: tb/tb_red_pitaya_fads_mc.sv
// tb_red_pitaya_fads_mc: randomized droplet stimulus checked against a per-droplet classification model
module tb_red_pitaya_fads_mc;
    localparam int CW = 10;
    localparam int WMAX = (1 << CW) - 1;
    localparam int LO = 16;
    localparam int HI = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [27:0] adc = '0;
    logic trig, busy;
    logic [3:0] debug;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, eval_cyc = 0, rise_cyc = 0, rises = 0, trig_cycles = 0;
    logic prev_trig = 1'b0;
    int m_det = 0, m_pos = 0, m_short = 0, m_long = 0, m_sorted = 0, m_missed = 0;
    int m_wlow = 1, m_whigh = WMAX;
    logic [1:0] m_mask = 2'b01;
    int e_w, e_p0, e_p1;

    red_pitaya_fads_mc_if bus ();

    red_pitaya_fads_mc #(.NCH(2), .DWT(14), .CW(CW)) dut (
        .adc_clk_i (clk),
        .adc_rst_i (rst),
        .adc_i     (adc),
        .sort_trig (trig),
        .busy      (busy),
        .debug     (debug),
        .sys       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (debug == 4'd3) eval_cyc = cyc;
        if (trig && !prev_trig) begin
            rise_cyc = cyc;
            rises++;
        end
        if (trig) trig_cycles++;
        prev_trig = trig;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.wdata = d;
        bus.wen = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.ren = 1'b1;
        @(negedge clk);
        bus.ren = 1'b0;
        d = bus.rdata;
        chk("ack", 32'(bus.ack), 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic chk_counters;
        rd(32'h100, 32'(m_det), "detected");
        rd(32'h104, 32'(m_pos), "positive");
        rd(32'h108, 32'(m_short), "short");
        rd(32'h10C, 32'(m_long), "long");
        rd(32'h110, 32'(m_sorted), "sorted");
        rd(32'h114, 32'(m_missed), "missed");
    endtask

    task automatic chk_last;
        rd(32'h120, 32'(e_w), "last_width");
        rd(32'h140, 32'(e_p0), "last_peak0");
        rd(32'h144, 32'(e_p1), "last_peak1");
    endtask

    task automatic classify(input int w, input int p0, input int p1);
        bit pos;
        pos = w >= m_wlow && w < m_whigh
            && (!m_mask[0] || (p0 >= LO && p0 < HI))
            && (!m_mask[1] || (p1 >= LO && p1 < HI));
        m_det++;
        if (pos) m_pos++;
        if (pos) m_sorted++;
        if (w < m_wlow) m_short++;
        if (w >= m_whigh) m_long++;
        e_w = w;
        e_p0 = p0;
        e_p1 = p1;
    endtask

    // one droplet of len samples on ch0 (gate); f0/f1 nonzero fix the amplitudes, else random
    task automatic drop(input int len, input int f0, input int f1, input int gap);
        int s0, s1, p0, p1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            s0 = f0 != 0 ? f0 : int'($urandom_range(280)) + 20;
            s1 = f1 != 0 ? f1 : int'($urandom_range(420)) - 100;
            adc = {14'(s1), 14'(s0)};
            p0 = (i == 0 || s0 > p0) ? s0 : p0;
            p1 = (i == 0 || s1 > p1) ? s1 : p1;
        end
        @(negedge clk);
        adc = '0;
        repeat (gap) @(negedge clk);
        classify(len > WMAX ? WMAX : len, p0, p1);
    endtask

    task automatic wait_trig;
        int n = 0;
        while (!trig && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("trig_seen", 32'(trig), 32'd1);
    endtask

    initial begin
        int r0, t0, s0, hw;
        bus.addr = '0;
        bus.wdata = '0;
        bus.sel = 4'hF;
        bus.wen = 1'b0;
        bus.ren = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(trig), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_debug", 32'(debug), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_rdata", bus.rdata, 0);
        rst = 1'b0;
        rd(32'h00, 32'h3, "rst_ctrl");
        rd(32'h04, 32'd15, "rst_min_thr");
        rd(32'h08, 32'd0, "rst_hyst");
        rd(32'h10, 32'd1, "rst_wlow");
        rd(32'h14, 32'(WMAX), "rst_whigh");
        rd(32'h18, 32'd0, "rst_delay");
        rd(32'h1C, 32'(125000 % (WMAX + 1)), "rst_dur");
        rd(32'h20, 32'd1, "rst_chmask");
        rd(32'h40, 32'd16, "rst_low0");
        rd(32'h4C, 32'd255, "rst_high1");
        rd(32'h200, 32'd0, "unmapped");
        chk_counters();

        bus_write(32'h10, 5);
        bus_write(32'h14, 50);
        bus_write(32'h18, 10);
        bus_write(32'h1C, 8);
        bus_write(32'h100, 32'h55);
        rd(32'h100, 32'd0, "ro_write_ignored");
        m_wlow = 5;
        m_whigh = 50;
        t0 = trig_cycles;
        drop(20, 100, 50, 30);
        chk("plan_trig_len", 32'(trig_cycles - t0), 32'd8);
        chk("plan_trig_delay", 32'(rise_cyc - eval_cyc), 32'd11);
        chk_last();
        chk_counters();

        bus_write(32'h20, 3);
        m_mask = 2'b11;
        r0 = rises;
        drop(20, 100, 300, 30);
        chk("ch1_no_trig", 32'(rises - r0), 0);
        chk_last();
        chk_counters();

        r0 = rises;
        t0 = trig_cycles;
        s0 = m_sorted;
        for (int i = 0; i < 12; i++) begin
            m_mask = 2'($urandom_range(1, 3));
            bus_write(32'h20, 32'(m_mask));
            drop(int'($urandom_range(1, 60)), 0, 0, 30);
            chk_last();
        end
        chk_counters();
        chk("rnd_pulses", 32'(rises - r0), 32'(m_sorted - s0));
        chk("rnd_trig_cycles", 32'(trig_cycles - t0), 32'(8 * (m_sorted - s0)));

        bus_write(32'h20, 1);
        m_mask = 2'b01;
        drop(20, 100, 50, 0);
        wait_trig();
        repeat (3) begin
            @(negedge clk);
            adc = {14'd0, 14'd100};
        end
        @(negedge clk);
        adc = '0;
        m_missed++;
        repeat (30) @(negedge clk);
        chk_last();
        chk_counters();

        drop(20, 100, 50, 0);
        wait_trig();
        bus_write(32'h00, 32'h7);
        @(negedge clk);
        chk("softrst_trig", 32'(trig), 0);
        chk("softrst_debug", 32'(debug), 0);
        m_sorted--;
        chk_counters();
        bus_write(32'h00, 32'h3);
        repeat (5) @(negedge clk);

        bus_write(32'h08, 5);
`ifdef FADS_HYST_EN
        rd(32'h08, 32'd5, "hyst_reg");
        hw = 15;
`else
        rd(32'h08, 32'd0, "hyst_reg");
        hw = 5;
`endif
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            adc = {14'd0, i < 5 ? 14'd100 : 14'd12};
        end
        @(negedge clk);
        adc = '0;
        repeat (30) @(negedge clk);
        classify(hw, 100, 0);
        chk_last();
        chk_counters();
        bus_write(32'h08, 0);

        bus_write(32'h10, 1);
        bus_write(32'h14, 32'hFFFF_FFFF);
        m_wlow = 1;
        m_whigh = WMAX;
        drop(WMAX + 80, 100, 50, 30);
        chk_last();
        chk_counters();

        bus_write(32'h00, 32'hB);
        rd(32'h00, 32'h3, "ctrl_clr_reads0");
        m_det = 0;
        m_pos = 0;
        m_short = 0;
        m_long = 0;
        m_sorted = 0;
        m_missed = 0;
        chk_counters();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
